trans_feeder: RTL

Byte-to-transaction front end that sits upstream of the transaction validator and drives its `valid`/`ack` input handshake. It assembles an incoming byte stream into 128-bit transaction words and buffers them in a small FIFO. It presents one word at a time, holding it until the validator acknowledges. It also marks block boundaries (bit 9), discards stalled partial words after an idle timeout, and counts acknowledged transactions.

---
 rtl/trans_feeder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/trans_feeder.sv
// Purpose: packs a byte stream into 128-bit transaction words, queues them and feeds the validator.
// Latency: 16th byte at edge N -> valid_o high after edge N+1 (FIFO empty, FSM idle).
// Backpressure: byte_ready_o drops only for the 16th byte of a word while the FIFO is full.
module trans_feeder #(
    parameter int DEPTH        = 4,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   byte_i,
    input  logic         byte_valid_i,
    output logic         byte_ready_o,
    input  logic         block_start_i,
    output logic [127:0] data_o,
    output logic         valid_o,
    input  logic         ack_i,
    output logic [15:0]  sent_count_o,
    output logic         drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    typedef struct packed {
        logic [47:0] sender;
        logic [47:0] receiver;
        logic [21:0] amount;
        logic        block_start;
        logic [8:0]  rsvd;
    } txn_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_GAP
    } state_t;

    state_t         state;
    logic [3:0]     byte_cnt;
    logic [119:0]   shift_q;
    logic [IW-1:0]  idle_cnt;
    logic           bs_pending;

    logic [127:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_cnt;

    logic           fifo_full;
    logic           fifo_empty;
    logic           byte_acc;
    logic           fifo_wr;
    logic           fifo_pop;
    txn_t           wr_word;

    assign fifo_full    = (fifo_cnt == CW'(DEPTH));
    assign fifo_empty   = (fifo_cnt == '0);
    // Full check uses pre-pop occupancy so ready never depends on ack_i.
    assign byte_ready_o = !(fifo_full && (byte_cnt == 4'd15));
    assign byte_acc     = byte_valid_i && byte_ready_o;
    assign fifo_wr      = byte_acc && (byte_cnt == 4'd15);
    assign fifo_pop     = (state == S_PRESENT) && ack_i;

    always_comb begin
        wr_word = txn_t'({shift_q, byte_i});
        wr_word.block_start = wr_word.block_start | bs_pending | block_start_i;
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt     <= 4'd0;
            shift_q      <= '0;
            idle_cnt     <= '0;
            bs_pending   <= 1'b1;
            drop_o       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            state        <= S_IDLE;
            data_o       <= '0;
            valid_o      <= 1'b0;
            sent_count_o <= 16'd0;
        end else begin
            if (byte_acc) begin
                idle_cnt <= '0;
                if (byte_cnt == 4'd15) begin
                    byte_cnt <= 4'd0;
                end else begin
                    byte_cnt <= byte_cnt + 4'd1;
                    shift_q  <= {shift_q[111:0], byte_i};
                end
            end else if (byte_cnt != 4'd0) begin
                // Stalled partial word: drop it once the idle budget is spent.
                if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
                    byte_cnt <= 4'd0;
                    idle_cnt <= '0;
                    drop_o   <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end

            if (fifo_wr) begin
                bs_pending <= 1'b0;
            end else if (block_start_i) begin
                bs_pending <= 1'b1;
            end

            if (fifo_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (fifo_wr && !fifo_pop) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (fifo_pop && !fifo_wr) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        data_o  <= mem[rd_ptr];
                        valid_o <= 1'b1;
                        state   <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (ack_i) begin
                        sent_count_o <= sent_count_o + 16'd1;
                        valid_o      <= 1'b0;
                        state        <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    valid_o <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
